// File: rtl/sram_pkg.sv
// Shared types and limits for the clocked single-port SRAM controller.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int LANE_W     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Index width that still works for a single-word array.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response bundle between a requester (master) and sram_ctrl (slave).
interface sram_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  import sram_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [DATA_W/LANE_W-1:0] req_be;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     clr;
  logic                     busy;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, clr,
    input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, clr,
    output req_ready, busy, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_rd_pipe.sv
// RD_LAT-stage shift register carrying {valid, err, rdata}; fixed latency RD_LAT,
// no backpressure (a stage is always overwritten by its predecessor).
module sram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic              err_d,
  input  logic [DATA_W-1:0] rdata_d,
  output logic              valid_q,
  output logic              err_q,
  output logic [DATA_W-1:0] rdata_q
);

  logic [RD_LAT-1:0] stg_valid;
  logic [RD_LAT-1:0] stg_err;
  logic [DATA_W-1:0] stg_rdata [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      stg_err   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        stg_rdata[i] <= '0;
      end
    end else begin
      stg_valid[0] <= valid_d;
      stg_err[0]   <= err_d;
      stg_rdata[0] <= rdata_d;
      for (int i = 1; i < RD_LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_err[i]   <= stg_err[i-1];
        stg_rdata[i] <= stg_rdata[i-1];
      end
    end
  end

  assign valid_q = stg_valid[RD_LAT-1];
  assign err_q   = stg_err[RD_LAT-1];
  assign rdata_q = stg_rdata[RD_LAT-1];

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM with byte enables, zero-fill engine and RD_LAT-cycle response pipe.
// req_ready drops during the clear and in a clr cycle; responses are never stalled.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  if (DATA_W % LANE_W != 0) begin : g_bad_data_w
    $error("sram_ctrl: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("sram_ctrl: DEPTH must lie in 1..2**ADDR_W");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sram_ctrl: RD_LAT must lie in 1..4");
  end

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

  // Extra MSB keeps DEPTH == 2**ADDR_W from wrapping to zero in the compare.
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);
  assign idx      = bus.req_addr[IDX_W-1:0];

  assign bus.busy      = (state == CLEAR);
  assign bus.req_ready = (state == READY) && !bus.clr;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      READY: begin
        if (bus.clr) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Storage is not reset; the clear engine zero-fills it after every reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && bus.req_we && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.req_be[i]) begin
          mem[idx][i*LANE_W +: LANE_W] <= bus.req_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read data is captured by the first pipe stage at the accept edge.
  assign rd_err  = accept && !in_range;
  assign rd_data = (accept && !bus.req_we && in_range) ? mem[idx] : '0;

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_d (accept),
    .err_d   (rd_err),
    .rdata_d (rd_data),
    .valid_q (bus.rsp_valid),
    .err_q   (bus.rsp_err),
    .rdata_q (bus.rsp_rdata)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: dut_a uses the defaults, dut_b is 32-bit wide, 1000 deep, RD_LAT=3.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sram_ctrl_if #(.ADDR_W(10), .DATA_W(8))  ia ();
  sram_ctrl_if #(.ADDR_W(11), .DATA_W(32)) ib ();

  sram_ctrl #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  sram_ctrl #(.ADDR_W(11), .DATA_W(32), .DEPTH(1000), .RD_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  int          qa_cyc[$];
  logic [31:0] qa_dat[$];
  logic        qa_err[$];
  int          qb_cyc[$];
  logic [31:0] qb_dat[$];
  logic        qb_err[$];

  always @(negedge clk) begin
    if (ia.rsp_valid) begin
      qa_cyc.push_back(cyc);
      qa_dat.push_back(32'(ia.rsp_rdata));
      qa_err.push_back(ia.rsp_err);
    end
    if (ib.rsp_valid) begin
      qb_cyc.push_back(cyc);
      qb_dat.push_back(ib.rsp_rdata);
      qb_err.push_back(ib.rsp_err);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? ia.req_ready : ib.req_ready;
  endfunction

  function automatic logic bsy(input int d);
    return (d == 0) ? ia.busy : ib.busy;
  endfunction

  task automatic drive(input int d, input logic v, input logic we, input logic [3:0] be,
                       input logic [10:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      ia.req_valid = v;  ia.req_we = we;  ia.req_be = be[0:0];
      ia.req_addr = addr[9:0];  ia.req_wdata = wd[7:0];
    end else begin
      ib.req_valid = v;  ib.req_we = we;  ib.req_be = be;
      ib.req_addr = addr;  ib.req_wdata = wd;
    end
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 4'h0, 11'd0, 32'h0);
  endtask

  // Holds the request until accepted; acc is the cycle count right after the accept edge.
  task automatic req(input int d, input logic we, input logic [3:0] be,
                     input logic [10:0] addr, input logic [31:0] wd, output int acc);
    int n;
    n = 0;
    drive(d, 1'b1, we, be, addr, wd);
    #1;
    while (!rdy(d) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("req_ready_wait", rdy(d), 1);
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic pop(input int d, output int c, output logic [31:0] dat, output logic err);
    c = -100; dat = 'x; err = 1'bx;
    if (d == 0) begin
      if (qa_cyc.size() == 0) chk("rsp_present_a", qa_cyc.size(), 1);
      else begin
        c = qa_cyc.pop_front(); dat = qa_dat.pop_front(); err = qa_err.pop_front();
      end
    end else begin
      if (qb_cyc.size() == 0) chk("rsp_present_b", qb_cyc.size(), 1);
      else begin
        c = qb_cyc.pop_front(); dat = qb_dat.pop_front(); err = qb_err.pop_front();
      end
    end
  endtask

  task automatic count_busy(input int d, output int n);
    n = 0;
    while (bsy(d) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, c, c0;
    int          a0, a1, a2, ar [4];
    logic [31:0] dat;
    logic        err;

    idle(0); idle(1);
    ia.clr = 1'b0; ib.clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("rst_ready_a", ia.req_ready, 0);
    chk("rst_valid_a", ia.rsp_valid, 0);
    chk("rst_rdata_a", ia.rsp_rdata, 0);
    chk("rst_err_a",   ia.rsp_err, 0);
    chk("rst_busy_a",  ia.busy, 1);
    chk("rst_busy_b",  ib.busy, 1);
    chk("rst_ready_b", ib.req_ready, 0);

    rst = 1'b0;
    count_busy(0, n);
    chk("clear_cycles_a", n, 1024);
    chk("ready_after_clear_a", ia.req_ready, 1);
    chk("busy_done_b", ib.busy, 0);

    // Freshly cleared word reads as zero, one cycle after accept.
    req(0, 1'b0, 4'h0, 11'd5, 32'h0, a0);
    idle(0); wait_cyc(3);
    pop(0, c, dat, err);
    chk("rd5_lat", c - a0 + 1, 1);
    chk("rd5_data", dat, 32'h0);
    chk("rd5_err", err, 0);

    // Read-after-write on consecutive cycles.
    req(0, 1'b1, 4'h1, 11'd3, 32'hA5, a0);
    req(0, 1'b0, 4'h0, 11'd3, 32'h0, a1);
    idle(0); wait_cyc(3);
    pop(0, c, dat, err);
    chk("wr3_rsp_data", dat, 32'h0);
    chk("wr3_rsp_err", err, 0);
    c0 = c;
    pop(0, c, dat, err);
    chk("raw3_data", dat, 32'hA5);
    chk("raw3_err", err, 0);
    chk("raw3_b2b", c - c0, 1);

    // Byte-lane merge on the wide instance.
    req(1, 1'b1, 4'hF, 11'd7, 32'h11223344, a0);
    req(1, 1'b1, 4'h5, 11'd7, 32'hFFFFFFFF, a1);
    req(1, 1'b0, 4'h0, 11'd7, 32'h0, a2);
    idle(1); wait_cyc(6);
    pop(1, c, dat, err);
    pop(1, c, dat, err);
    pop(1, c, dat, err);
    chk("be_merge_data", dat, 32'h11FF33FF);
    chk("be_merge_lat", c - a2 + 1, 3);

    // Out-of-range accesses and the DEPTH boundary.
    req(1, 1'b1, 4'hF, 11'd1010, 32'hDEADBEEF, a0);
    req(1, 1'b0, 4'h0, 11'd1010, 32'h0, a0);
    req(1, 1'b0, 4'h0, 11'd999, 32'h0, a0);
    req(1, 1'b0, 4'h0, 11'd1000, 32'h0, a0);
    idle(1); wait_cyc(6);
    pop(1, c, dat, err);
    chk("oor_wr_err", err, 1);
    chk("oor_wr_data", dat, 32'h0);
    pop(1, c, dat, err);
    chk("oor_rd_err", err, 1);
    chk("oor_rd_data", dat, 32'h0);
    pop(1, c, dat, err);
    chk("rd999_data", dat, 32'h0);
    chk("rd999_err", err, 0);
    pop(1, c, dat, err);
    chk("rd1000_err", err, 1);

    // Back-to-back reads at RD_LAT=3.
    for (int i = 0; i < 4; i++) req(1, 1'b1, 4'hF, 11'(i), 32'(i + 1), a0);
    for (int i = 0; i < 4; i++) req(1, 1'b0, 4'h0, 11'(i), 32'h0, ar[i]);
    idle(1); wait_cyc(6);
    for (int i = 0; i < 4; i++) pop(1, c, dat, err);
    for (int i = 0; i < 4; i++) begin
      pop(1, c, dat, err);
      if (i == 0) c0 = c;
      chk($sformatf("b2b_data%0d", i), dat, 32'(i + 1));
      chk($sformatf("b2b_lat%0d", i), c - ar[i] + 1, 3);
      chk($sformatf("b2b_slot%0d", i), c - c0, i);
    end

    // clr with a simultaneous request: request refused, full clear follows.
    ib.clr = 1'b1;
    drive(1, 1'b1, 1'b0, 4'h0, 11'd0, 32'h0);
    #1;
    chk("clr_blocks_ready", ib.req_ready, 0);
    @(posedge clk); #1;
    ib.clr = 1'b0;
    idle(1);
    chk("clr_busy", ib.busy, 1);
    count_busy(1, n);
    chk("clear_cycles_b", n, 1000);
    wait_cyc(4);
    chk("clr_no_rsp", qb_cyc.size(), 0);
    req(1, 1'b0, 4'h0, 11'd0, 32'h0, a0);
    idle(1); wait_cyc(6);
    pop(1, c, dat, err);
    chk("after_clr_rd0", dat, 32'h0);

    // Reset at clear address 500 on dut_a, with a read in flight on dut_b.
    ia.clr = 1'b1;
    @(posedge clk); #1;
    ia.clr = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    req(1, 1'b0, 4'h0, 11'd1, 32'h0, a0);
    rst = 1'b1;
    idle(1);
    #1;
    chk("rst2_busy_a",  ia.busy, 1);
    chk("rst2_ready_a", ia.req_ready, 0);
    chk("rst2_valid_b", ib.rsp_valid, 0);
    chk("rst2_rdata_b", ib.rsp_rdata, 0);
    wait_cyc(3);
    @(negedge clk);
    rst = 1'b0;
    count_busy(0, n);
    chk("rst2_clear_cycles_a", n, 1024);
    chk("rst2_no_rsp_b", qb_cyc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised synchronous single-port SRAM with a valid/ready request port, per-byte write enables, a configurable read-latency pipeline and a hardware clear engine. It replaces the asynchronous-read RAM in the memory subsystem and serves as the storage core for buffers and register files that need deterministic, clocked access. After every reset, or on demand, it zero-fills the whole array before accepting traffic.

## Interface
- ADDR_W, 10, address width
- DATA_W, 8, data width; must be a multiple of 8
- DEPTH, 1024, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, request-accept-to-response latency in cycles; legal range 1..4

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_be  in  DATA_W/8  byte-lane write enables; ignored for reads
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- clr  in  1  start a full-array zero fill; pulse, sampled only in READY
- busy  out  1  clear in progress
- rsp_valid  out  1  response strobe; one per accepted request
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address ≥ DEPTH; valid only with rsp_valid

## Operation
- FSM states: CLEAR and READY.
- CLEAR:
  - Counter walks addresses 0..DEPTH-1, one word per cycle, writing 0.
  - After the DEPTH-1 write, the FSM moves to READY.
  - busy=1 and req_ready=0 throughout.
  - clr is ignored.
- READY:
  - req_ready = !clr.
  - clr=1 moves the FSM to CLEAR with the counter at 0. A req_valid in the same cycle is not accepted.
- A request is accepted when req_valid && req_ready.
- Write:
  - The array is updated at the accept edge. Lane i is written only when req_be[i]=1; other lanes hold their value.
  - An address ≥ DEPTH modifies nothing.
- Read: data is sampled from the array at the accept edge.
- Every accepted request produces exactly one response, in acceptance order. There is no response backpressure.
- Error response: when req_addr ≥ DEPTH, the response carries rsp_err=1 and rsp_rdata=0, for both reads and writes.
- Write response: rsp_rdata=0 and rsp_err=0 when the address is in range.
- Responses already in the pipeline when clr is taken still emerge on schedule, carrying their sampled data.

## Timing
- Reset values while rst is high:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - busy=1, FSM=CLEAR, clear counter=0, pipeline cleared.
- Clear duration: busy stays high for exactly DEPTH cycles after the first rising edge following rst deassertion. req_ready rises in the cycle after the last clear write.
- Latency: a request accepted at edge N has rsp_valid high for exactly one cycle after edge N+RD_LAT.
- Throughput: one request per cycle. Back-to-back requests give back-to-back responses.
- Read-after-write: a read accepted at edge N+1 after a write accepted at edge N to the same address returns the new data.
- Reset mid-clear or mid-pipeline: everything returns to reset values immediately. The clear restarts from address 0, and in-flight responses are discarded.
- Address width rule: compare req_addr against DEPTH at full ADDR_W width; there is no wrap-around.

## Structure
- Package sram_pkg:
  - State enum (CLEAR, READY).
  - Lane width constant 8.
  - RD_LAT_MIN=1 and RD_LAT_MAX=4.
- Top level sram_ctrl holds the memory array, the FSM, the clear counter and the request decode.
- Sub-module sram_rd_pipe is an RD_LAT-stage shift register carrying {valid, err, rdata}, reset asynchronously.
- Elaboration-time checks:
  - DATA_W % 8 == 0.
  - DEPTH ≤ 2^ADDR_W.
  - RD_LAT within 1..4.

## Test plan
- Defaults, release rst → busy high for 1024 cycles, then req_ready=1; read addr 5 → rsp_rdata=0x00 one cycle after accept.
- Write 0xA5 to addr 3, read addr 3 in the next cycle → rsp_rdata=0xA5, rsp_err=0.
- DATA_W=32:
  - Write 0x11223344 to addr 7 with be=4'b1111.
  - Write 0xFFFFFFFF to addr 7 with be=4'b0101.
  - Read addr 7 → 0x11FF33FF.
- DEPTH=1000:
  - Write to addr 1010 → response with rsp_err=1.
  - Read addr 1010 → rsp_rdata=0, rsp_err=1.
  - Read addr 999 is unaffected.
- RD_LAT=3:
  - Four back-to-back reads of addrs 0..3 holding 1..4 → rsp_valid high for four consecutive cycles starting at accept+3, data 1,2,3,4 in order.
  - clr asserted with req_valid → that request is not accepted; busy high for DEPTH cycles; afterwards read addr 0 → 0.
- Assert rst at clear address 500 → outputs return to reset values; after release, busy lasts a full DEPTH cycles.
